skid_reg: RTL

//   Registered 2-entry skid buffer with valid/ready handshake, placed directly downstream of
//   MUX2x1. It captures the selected datapath word into a pipeline register and decouples

---
 rtl/dp_pkg.sv | 11 +
 rtl/skid_reg.sv | 101 ++++++++++
 2 files changed

// File: rtl/dp_pkg.sv
// Shared datapath package: skid buffer state encoding and the
// default word width used by MUX2x1 and the downstream pipeline.
package dp_pkg;

  localparam int unsigned DP_WIDTH = 64;

  localparam logic [1:0] SKID_EMPTY = 2'b00;
  localparam logic [1:0] SKID_BUSY  = 2'b01;
  localparam logic [1:0] SKID_FULL  = 2'b10;

endpackage

// File: rtl/skid_reg.sv
// Registered 2-entry skid buffer with valid/ready handshakes.
// Ports: Clk, Rst (async, active-low), flush, in_* (producer), out_* (consumer), count.
module skid_reg
  import dp_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DP_WIDTH
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 flush,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           count
);

  logic [1:0]           state_q, state_d;
  logic [DATAWIDTH-1:0] main_q, main_d;
  logic [DATAWIDTH-1:0] skid_q, skid_d;
  logic                 out_valid_q, out_valid_d;
  logic                 in_ready_q, in_ready_d;
  logic                 in_fire;
  logic                 out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    if (flush) begin
      // main_q is left as-is; out_data is don't-care once invalid
      state_d     = SKID_EMPTY;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (in_fire) begin
            main_d      = in_data;
            out_valid_d = 1'b1;
            state_d     = SKID_BUSY;
          end
        end
        SKID_BUSY: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d     = in_data;
            in_ready_d = 1'b0;
            state_d    = SKID_FULL;
          end else if (out_fire) begin
            out_valid_d = 1'b0;
            state_d     = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (out_fire) begin
            main_d     = skid_q;
            in_ready_d = 1'b1;
            state_d    = SKID_BUSY;
          end
        end
        default: begin
          state_d     = SKID_EMPTY;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= SKID_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  // state encoding doubles as the occupancy count
  assign count     = state_q;

endmodule
